// File: rtl/phase_weight_pkg.sv
// Shared definitions for the phase-shifter weight loader.
//   state_t      : loader FSM encoding (IDLE / LOAD / PENDING)
//   ADDR_*       : config-port word addresses
//   DEF_W_WIDTH  : default weight word width
//   addr_onehot  : one-hot decode of a config address
package phase_weight_pkg;

  localparam int DEF_W_WIDTH = 5;
  localparam int NUM_W       = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PENDING = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_COS_1 = 2'd0;
  localparam logic [1:0] ADDR_SIN_1 = 2'd1;
  localparam logic [1:0] ADDR_COS_2 = 2'd2;
  localparam logic [1:0] ADDR_SIN_2 = 2'd3;

  function automatic logic [NUM_W-1:0] addr_onehot(input logic [1:0] addr);
    return NUM_W'(1) << addr;
  endfunction

endpackage

// File: rtl/phase_weight_loader_weight_bank.sv
// weight_bank: 4-entry x W_WIDTH register file, per-entry write enable,
// all entries read in parallel.
//   clock   : clock
//   reset   : synchronous active-low reset, loads RST_VAL
//   wr_en   : per-entry write enable
//   wr_data : per-entry write data
//   rd_data : registered contents of every entry
module weight_bank
  import phase_weight_pkg::*;
#(
  parameter int                              W_WIDTH = DEF_W_WIDTH,
  parameter logic [NUM_W-1:0][W_WIDTH-1:0]   RST_VAL = '0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_W-1:0]                  wr_en,
  input  logic [NUM_W-1:0][W_WIDTH-1:0]     wr_data,
  output logic [NUM_W-1:0][W_WIDTH-1:0]     rd_data
);

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_W; i++) begin
      if (!reset)        rd_data[i] <= RST_VAL[i];
      else if (wr_en[i]) rd_data[i] <= wr_data[i];
    end
  end

endmodule

// File: rtl/phase_weight_loader.sv
// phase_weight_loader: collects four weight words over a valid/ready config
// port into a shadow bank, then commits them atomically to the active bank on
// a frame_sync strobe, so the phase shifter never sees a partial or mid-frame
// weight update.
//   clock, reset         : clock, synchronous active-low reset
//   cfg_valid/cfg_ready  : config handshake; cfg_addr selects the weight,
//                          cfg_data is the signed word
//   cfg_abort            : drop the partially/fully loaded shadow, back to IDLE
//   frame_sync           : frame-boundary strobe; commits when all 4 loaded
//   w_cos_1..w_sin_2     : active weights (registered)
//   commit_p             : 1-cycle pulse aligned with new weights on outputs
// Optional status (macro PHASE_WEIGHT_STATUS_EN):
//   commit_cnt           : 8-bit wrapping commit counter
//   overrun              : sticky, frame_sync seen while still loading
module phase_weight_loader
  import phase_weight_pkg::*;
#(
  parameter int                         W_WIDTH   = DEF_W_WIDTH,
  parameter logic signed [W_WIDTH-1:0]  RST_COS_1 = '0,
  parameter logic signed [W_WIDTH-1:0]  RST_COS_2 = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [1:0]                 cfg_addr,
  input  logic signed [W_WIDTH-1:0]  cfg_data,
  input  logic                       cfg_abort,
  input  logic                       frame_sync,
  output logic signed [W_WIDTH-1:0]  w_cos_1,
  output logic signed [W_WIDTH-1:0]  w_sin_1,
  output logic signed [W_WIDTH-1:0]  w_cos_2,
  output logic signed [W_WIDTH-1:0]  w_sin_2,
`ifdef PHASE_WEIGHT_STATUS_EN
  output logic [7:0]                 commit_cnt,
  output logic                       overrun,
`endif
  output logic                       commit_p
);

  // Entry order in the packed banks follows the config address map.
  localparam logic [NUM_W-1:0][W_WIDTH-1:0] ACT_RST =
    {W_WIDTH'(0), RST_COS_2, W_WIDTH'(0), RST_COS_1};

  state_t                         state, state_nxt;
  logic [NUM_W-1:0]               mask, mask_nxt;
  logic                           xfer, commit;
  logic [NUM_W-1:0]               sh_wr_en;
  logic [NUM_W-1:0][W_WIDTH-1:0]  sh_q, act_q;

  // Ready is forced low while reset is asserted, not just after it.
  assign cfg_ready = reset && (state != PENDING);
  // Abort wins over a simultaneous transfer: the shadow is left as it was.
  assign xfer      = cfg_valid && cfg_ready && !cfg_abort;
  assign commit    = (state == PENDING) && frame_sync && !cfg_abort;
  assign sh_wr_en  = xfer ? addr_onehot(cfg_addr) : '0;

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    if (cfg_abort) begin
      state_nxt = IDLE;
      mask_nxt  = '0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (xfer) begin
            mask_nxt  = mask | addr_onehot(cfg_addr);
            state_nxt = (&mask_nxt) ? PENDING : LOAD;
          end
        end
        PENDING: begin
          if (frame_sync) begin
            state_nxt = IDLE;
            mask_nxt  = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          mask_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      mask     <= '0;
      commit_p <= 1'b0;
    end else begin
      state    <= state_nxt;
      mask     <= mask_nxt;
      commit_p <= commit;
    end
  end

  weight_bank #(.W_WIDTH(W_WIDTH), .RST_VAL('0)) u_shadow (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (sh_wr_en),
    .wr_data ({NUM_W{cfg_data}}),
    .rd_data (sh_q)
  );

  weight_bank #(.W_WIDTH(W_WIDTH), .RST_VAL(ACT_RST)) u_active (
    .clock   (clock),
    .reset   (reset),
    .wr_en   ({NUM_W{commit}}),
    .wr_data (sh_q),
    .rd_data (act_q)
  );

  assign w_cos_1 = act_q[ADDR_COS_1];
  assign w_sin_1 = act_q[ADDR_SIN_1];
  assign w_cos_2 = act_q[ADDR_COS_2];
  assign w_sin_2 = act_q[ADDR_SIN_2];

`ifdef PHASE_WEIGHT_STATUS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      commit_cnt <= '0;
      overrun    <= 1'b0;
    end else begin
      if (commit) commit_cnt <= commit_cnt + 8'd1;
      if (cfg_abort)                             overrun <= 1'b0;
      else if (frame_sync && (state == LOAD))    overrun <= 1'b1;
    end
  end
`endif

endmodule
